// File: rtl/inst_fetch_stage_if.sv
// Bundle of handshake and bus signals between the IF stage, its control
// sources (hazard unit, branch/jump resolution), the instruction ROM and ID.
interface inst_fetch_stage_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic [15:0] squash_count;

  // Environment side: drives control and ROM data, observes the stage.
  modport master (
    output stall, br_taken, br_target, jump, jump_target, rom_inst,
    input  rom_addr, if_id_inst, if_id_pc4, if_id_valid, fetch_count, squash_count
  );

  // Fetch stage side.
  modport slave (
    input  stall, br_taken, br_target, jump, jump_target, rom_inst,
    output rom_addr, if_id_inst, if_id_pc4, if_id_valid, fetch_count, squash_count
  );
endinterface

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, presents it to the ROM with no added
// latency, and captures the returned word into the IF/ID register. Branch and
// jump redirects squash the in-flight fetch to a bubble and take priority over
// hazard stalls.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_stage_if.slave bus
);

  logic [31:0] pc_q,         pc_d;
  logic [31:0] inst_q,       inst_d;
  logic [31:0] pc4_q,        pc4_d;
  logic        valid_q,      valid_d;
  logic [31:0] fetch_cnt_q,  fetch_cnt_d;
  logic [15:0] squash_cnt_q, squash_cnt_d;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;

  assign pc_plus4 = pc_q + 32'd4;  // wraps naturally modulo 2^32
  assign redirect = bus.br_taken | bus.jump;
  // The branch is the older instruction, so it wins over a same-cycle jump.
  assign redirect_pc = bus.br_taken ? {bus.br_target[31:2], 2'b00}
                                    : {bus.jump_target[31:2], 2'b00};

  // Next-state selection: redirect, then stall, then normal sequential fetch.
  always_comb begin
    // NOTE: every next-state signal is defaulted to "hold" before any branch
    // of the priority chain, so no path can leave one unassigned (no latch).
    pc_d         = pc_q;
    inst_d       = inst_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    squash_cnt_d = squash_cnt_q;

    if (redirect) begin
      // The word fetched this cycle is on the wrong path: replace with a bubble.
      pc_d    = redirect_pc;
      inst_d  = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (squash_cnt_q != 16'hFFFF) squash_cnt_d = squash_cnt_q + 16'd1;
    end else if (!bus.stall) begin
      pc_d        = pc_plus4;
      inst_d      = bus.rom_inst;
      pc4_d       = pc_plus4;
      valid_d     = 1'b1;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // State registers; reset is asynchronous so the PC snaps back without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inst_q       <= NOP_WORD;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
      fetch_cnt_q  <= 32'd0;
      squash_cnt_q <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign bus.rom_addr     = pc_q;
  assign bus.if_id_inst   = inst_q;
  assign bus.if_id_pc4    = pc4_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.fetch_count  = fetch_cnt_q;
  assign bus.squash_count = squash_cnt_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage. A behavioural model tracks the
// architectural fetch stream (current PC, last delivered instruction, counters)
// and is compared against the DUT on every falling edge; directed steps add
// hand-computed literal expectations.
module tb_inst_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic clk;
  logic rst_n;
  inst_fetch_stage_if bus ();

  inst_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ROM model: combinational, word = base + byte address.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + addr;
  endfunction
  assign bus.rom_inst = rom_word(bus.rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What the pipeline has architecturally: where fetch points, what ID holds,
  // and how many deliveries / redirects have happened.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fetched;
    int          squashes;   // unbounded; the visible counter saturates
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.pc = RESET_PC; r.inst = NOP_WORD; r.pc4 = 0; r.valid = 0;
    r.fetched = 0; r.squashes = 0;
    return r;
  endfunction

  initial m = model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m = model_reset();
    else if (bus.br_taken || bus.jump) begin
      // One redirect event; the older (branch) target is taken if both fire.
      m.pc       = (bus.br_taken ? bus.br_target : bus.jump_target) & 32'hFFFF_FFFC;
      m.inst     = NOP_WORD;
      m.pc4      = 0;
      m.valid    = 0;
      m.squashes = m.squashes + 1;
    end else if (!bus.stall) begin
      m.inst    = rom_word(m.pc);
      m.pc4     = m.pc + 32'd4;
      m.pc      = m.pc4;
      m.valid   = 1;
      m.fetched = m.fetched + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_rom_addr", bus.rom_addr,    m.pc);
      check("cyc_inst",     bus.if_id_inst,  m.inst);
      check("cyc_pc4",      bus.if_id_pc4,   m.pc4);
      check("cyc_valid",    {31'd0, bus.if_id_valid}, {31'd0, m.valid});
      check("cyc_fetch",    bus.fetch_count, m.fetched);
      check("cyc_squash",   {16'd0, bus.squash_count},
            (m.squashes > 65535) ? 32'h0000_FFFF : 32'(m.squashes));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input bit st, input bit br, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt);
    bus.stall = st; bus.br_taken = br; bus.br_target = bt;
    bus.jump = j; bus.jump_target = jt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic expect_if(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                           input logic [31:0] pc4, input bit valid,
                           input logic [31:0] fc, input logic [15:0] sc);
    check({tag, "_rom_addr"}, bus.rom_addr,    addr);
    check({tag, "_inst"},     bus.if_id_inst,  inst);
    check({tag, "_pc4"},      bus.if_id_pc4,   pc4);
    check({tag, "_valid"},    {31'd0, bus.if_id_valid}, {31'd0, valid});
    check({tag, "_fetch"},    bus.fetch_count, fc);
    check({tag, "_squash"},   {16'd0, bus.squash_count}, {16'd0, sc});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 0; bus.br_taken = 0; bus.br_target = 0;
    bus.jump = 0; bus.jump_target = 0;
    #12;
    expect_if("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    check_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("t1_first_addr", bus.rom_addr, 32'h0);

    // T1: free-run from RESET_PC
    run(1);
    expect_if("t1_e1", 32'h4, 32'h1000_0000, 32'h4, 1, 1, 0);
    run(1);
    expect_if("t1_e2", 32'h8, 32'h1000_0004, 32'h8, 1, 2, 0);

    // T2: stall two cycles at pc=8, everything frozen, then release
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_if("t2_stall", 32'h8, 32'h1000_0004, 32'h8, 1, 2, 0);
    run(1);
    expect_if("t2_release", 32'hC, 32'h1000_0008, 32'hC, 1, 3, 0);

    // T3: walk to pc=0x1C, then branch to misaligned 0x23
    run(4);
    check("t3_at_1c", bus.rom_addr, 32'h1C);
    step(0, 1, 32'h0000_0023, 0, 0);
    expect_if("t3_branch", 32'h20, NOP_WORD, 32'h0, 0, 7, 1);
    run(1);
    expect_if("t3_after", 32'h24, 32'h1000_0020, 32'h24, 1, 8, 1);

    // T4: branch + jump + stall together: branch wins, one squash
    step(1, 1, 32'h40, 1, 32'h80);
    expect_if("t4_all", 32'h40, NOP_WORD, 32'h0, 0, 8, 2);

    // Jump beats stall
    step(1, 0, 0, 1, 32'h100);
    expect_if("jmp_stall", 32'h100, NOP_WORD, 32'h0, 0, 8, 3);

    // T5: jump to top of memory (low bits ignored), then wrap
    step(0, 0, 0, 1, 32'hFFFF_FFFF);
    check("t5_top", bus.rom_addr, 32'hFFFF_FFFC);
    run(1);
    expect_if("t5_wrap", 32'h0, 32'h0FFF_FFFC, 32'h0, 1, 9, 4);
    run(1);
    expect_if("t5_next", 32'h4, 32'h1000_0000, 32'h4, 1, 10, 4);

    // A NOP word on the normal path is still valid and counted (ROM gives 0 at 0xF000_0000)
    step(0, 0, 0, 1, 32'hF000_0002);
    run(1);
    expect_if("nop_valid", 32'hF000_0004, 32'h0, 32'hF000_0004, 1, 11, 5);

    // T6: async reset between edges during a stall
    step(1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    expect_if("t6_async", RESET_PC, NOP_WORD, 32'h0, 0, 0, 0);
    @(negedge clk);
    bus.stall = 0;
    rst_n = 1'b1;
    run(2);
    expect_if("t6_restart", 32'h8, 32'h1000_0004, 32'h8, 1, 2, 0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
